// File: rtl/seq_divider_16by8_pkg.sv
// div_pkg: shared state encoding and width constants for the sequential divider.
package div_pkg;
  localparam int DIV_N = 8;
  localparam logic [DIV_N-1:0] DIV_ERR_Q = '1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
endpackage

// File: rtl/seq_divider_16by8_if.sv
// seq_divider_16by8_if: operand/result handshake bundle between divider and its client.
interface seq_divider_16by8_if
  import div_pkg::*;
#(parameter int N = DIV_N);
  logic in_valid, in_ready, out_valid, out_ready, div_by_zero, overflow;
  logic [2*N-1:0] dividend;
  logic [N-1:0] divisor, quotient, remainder;
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_16by8_div_step.sv
// div_step: one restoring-division iteration (trial subtract and select).
module div_step #(parameter int N = 8) (
  input  logic [N:0]   i_t,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_r,
  output logic         o_bit
);
  logic [N+1:0] w_diff;
  assign w_diff = {1'b0, i_t} - {2'b00, i_d};
  // R < D is invariant, so a non-negative difference always fits in N bits
  assign o_bit = ~|w_diff[N+1:N];
  assign o_r = o_bit ? w_diff[N-1:0] : i_t[N-1:0];
endmodule

// File: rtl/seq_divider_16by8.sv
// seq_divider_16by8: 2N/N restoring divider, one quotient bit per cycle behind valid/ready.
module seq_divider_16by8
  import div_pkg::*;
#(parameter int N = DIV_N) (
  input logic clk,
  input logic rst_n,
  seq_divider_16by8_if.slave bus
);
  localparam int CW = $clog2(N);
  div_state_t r_state, w_next;
  logic [N-1:0] r_r, r_q, r_d, r_quot, r_rem, w_r;
  logic [CW-1:0] r_cnt;
  logic r_dbz, r_ovf, w_bit, w_acc, w_zero, w_ovf, w_last;
  assign w_acc = bus.in_valid && r_state == IDLE;
  assign w_zero = bus.divisor == '0;
  assign w_ovf = !w_zero && bus.dividend[2*N-1:N] >= bus.divisor;
  assign w_last = r_cnt == CW'(N-1);
  div_step #(.N(N)) u_step (
    .i_t  ({r_r, r_q[N-1]}),
    .i_d  (r_d),
    .o_r  (w_r),
    .o_bit(w_bit)
  );
  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && bus.in_valid) w_next = (w_zero || w_ovf) ? DONE : CALC;
    else if (r_state == CALC && w_last) w_next = DONE;
    else if (r_state == DONE && bus.out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r <= '0;
      r_q <= '0;
      r_d <= '0;
      r_cnt <= '0;
      r_quot <= '0;
      r_rem <= '0;
      r_dbz <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_acc) begin
      r_r <= bus.dividend[2*N-1:N];
      r_q <= bus.dividend[N-1:0];
      r_d <= bus.divisor;
      r_cnt <= '0;
      r_dbz <= w_zero;
      r_ovf <= w_ovf;
      if (w_zero || w_ovf) begin
        r_quot <= '1;
        r_rem <= '0;
      end
    end else if (r_state == CALC) begin
      r_r <= w_r;
      r_q <= {r_q[N-2:0], w_bit};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_quot <= {r_q[N-2:0], w_bit};
        r_rem <= w_r;
      end
    end
  end
  assign bus.in_ready = r_state == IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.quotient = r_quot;
  assign bus.remainder = r_rem;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_seq_divider_16by8.sv
// tb_seq_divider_16by8: directed and random operations checked against an arithmetic model.
module tb_seq_divider_16by8;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  seq_divider_16by8_if #(.N(8)) bus ();
  seq_divider_16by8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic z, output logic o);
    int qi;
    z = 1'b0; o = 1'b0; q = 8'hFF; r = 8'h00;
    if (b == 0) z = 1'b1;
    else begin
      qi = int'(a) / int'(b);
      if (qi > 255) o = 1'b1;
      else begin
        q = 8'(qi);
        r = 8'(int'(a) % int'(b));
      end
    end
  endfunction

  task automatic run(input logic [15:0] a, input logic [7:0] b, input int hold);
    logic [7:0] eq, er;
    logic ez, eo;
    int lat;
    model(a, b, eq, er, ez, eo);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.dividend = a; bus.divisor = b;
    step();
    bus.in_valid = 1'b0; bus.dividend = 16'($urandom); bus.divisor = 8'($urandom);
    if (!(ez || eo)) chk("in_ready_calc", bus.in_ready, 0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, (ez || eo) ? 1 : 9);
    chk("quotient", bus.quotient, eq);
    chk("remainder", bus.remainder, er);
    chk("div_by_zero", bus.div_by_zero, ez);
    chk("overflow", bus.overflow, eo);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.dividend = 16'($urandom); bus.divisor = 8'($urandom);
      step();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_ready", bus.in_ready, 0);
      chk("hold_q", bus.quotient, eq);
      chk("hold_r", bus.remainder, er);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("post_in_ready", bus.in_ready, 1);
    chk("post_out_valid", bus.out_valid, 0);
    chk("post_q_held", bus.quotient, eq);
  endtask

  initial begin
    logic [7:0] dv, hi;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) step();
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_flags", {bus.div_by_zero, bus.overflow}, 0);
    rst_n = 1'b1;
    step();
    run(16'h03E8, 8'd7, 0);
    run(16'hFEFF, 8'hFF, 0);
    run(16'hFFFF, 8'hFF, 0);
    run(16'h1234, 8'h00, 0);
    run(16'h03E8, 8'd7, 5);
    run(16'h00FF, 8'd1, 0);
    run(16'h0100, 8'd1, 0);
    run(16'h0000, 8'd3, 0);
    bus.in_valid = 1'b1; bus.dividend = 16'h1234; bus.divisor = 8'h56;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_outputs", {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, 0);
    step();
    chk("midrst_stays_idle", bus.out_valid, 0);
    run(16'h0064, 8'h0A, 0);
    for (int k = 0; k < 40; k++) begin
      dv = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, int'(dv) - 1));
      if (k % 8 == 7) run(16'($urandom), 8'($urandom_range(0, 3)), 0);
      else run({hi, 8'($urandom)}, dv, k % 5 == 0 ? 2 : 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_divider_16by8.md
# seq_divider_16by8

Sequential radix-2 restoring divider: the inverse of the 8x8 Dadda multiplier datapath. It takes a 16-bit dividend (the multiplier's product width) and an 8-bit divisor, and returns an 8-bit quotient and an 8-bit remainder. It produces one quotient bit per cycle behind valid/ready handshakes on input and output. It sits beside the multiplier in the arithmetic datapath and also serves as the self-check partner for multiplier products.

## Interface
- `N`, default 8: divisor, quotient and remainder width. The dividend width is 2N.
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  synchronous reset, active-low
- `in_valid`  input  1  operands presented
- `in_ready`  output  1  divider idle; high exactly when state is IDLE
- `dividend`  input  2N  unsigned dividend
- `divisor`  input  N  unsigned divisor
- `out_valid`  output  1  result valid; high exactly when state is DONE
- `out_ready`  input  1  consumer accepts the result
- `quotient`  output  N  unsigned quotient
- `remainder`  output  N  unsigned remainder
- `div_by_zero`  output  1  divisor was 0
- `overflow`  output  1  quotient does not fit in N bits, i.e. `dividend[2N-1:N] >= divisor` with `divisor != 0`

## Operation
- **States.** IDLE, CALC, DONE. All state changes occur on the rising edge of `clk`.
- **Reset.** When `rst_n` is 0 at an edge:
  - state goes to IDLE and the iteration counter to 0;
  - `quotient`, `remainder`, `div_by_zero` and `overflow` go to 0;
  - `out_valid` is 0 and `in_ready` is 1;
  - reset takes priority over every other event, including mid-CALC and mid-DONE; any in-flight operation is discarded.
- **IDLE.** An input handshake is `in_valid && in_ready`. On the handshake edge:
  - If `divisor == 0`: go to DONE with `div_by_zero = 1`, `overflow = 0`, `quotient = all-ones`, `remainder = 0`.
  - Else if overflow: go to DONE with `overflow = 1`, `div_by_zero = 0`, `quotient = all-ones`, `remainder = 0`.
  - Otherwise:
    - load the partial remainder `R` (N+1 bits) with `{0, dividend[2N-1:N]}`;
    - load the shift register `Q` with `dividend[N-1:0]`;
    - load `D` with `divisor`;
    - set counter = 0, clear both flags, and go to CALC.
- **CALC.** One iteration per edge:
  - `T = {R[N-1:0], Q[N-1]}`, N+1 bits;
  - `diff = T - {0, D}`, computed N+2 bits wide;
  - if `diff >= 0`: `R = diff` and the new bit is 1; else `R = T` and the new bit is 0;
  - `Q = {Q[N-2:0], bit}`;
  - the invariant `R < D` holds entry to exit, so `T` never exceeds 2D-1 and no bits are lost;
  - on the edge where counter == N-1: move to DONE, drive `quotient = Q` and `remainder = R[N-1:0]`; otherwise increment the counter.
- **DONE.** Outputs are held stable until the output handshake.
  - `out_valid && out_ready` at an edge returns the block to IDLE.
  - `quotient`, `remainder` and the flags keep their values in IDLE until the next accept.
- `in_valid` is ignored outside IDLE. `dividend` and `divisor` are sampled only on the accept edge; later changes have no effect.

## Timing
- **Normal latency.** N+1 edges from the accept edge to `out_valid` rising: the load edge plus N iteration edges. For N = 8, `out_valid` is high in the 9th cycle after acceptance.
- **Error latency.** 1 edge: `out_valid` is high in the cycle after the accept edge.
- **Throughput.** Minimum 1 operation per N+2 cycles when `out_ready` is held at 1. There is no overlap: `in_ready` is 0 throughout CALC and DONE.
- **Combinational paths.** None from inputs to outputs. `in_ready` and `out_valid` are decoded from the state register only.
- **Critical path.** One N+2-bit subtract followed by a mux.

## Structure
- **Package `div_pkg`.**
  - state enum `div_state_t`: IDLE, CALC, DONE;
  - localparam `DIV_N = 8`;
  - error quotient constant `DIV_ERR_Q = all-ones`.
- **Sub-module `div_step`.** Purely combinational: inputs `T` and `D`, outputs the new `R` and the quotient bit. It is instantiated once, inside the top-level sequential controller.

## Test plan
- 1000 / 7 (dividend 0x03E8): `quotient = 142` (0x8E), `remainder = 6`, flags 0, `out_valid` high 9 cycles after accept.
- 0xFEFF / 0xFF: `quotient = 0xFF`, `remainder = 0xFE` (254), no overflow.
- 0xFFFF / 0xFF: `overflow = 1`, `quotient = 0xFF`, `remainder = 0`, `out_valid` high 1 cycle after accept.
- 0x1234 / 0: `div_by_zero = 1`, `overflow = 0`, `quotient = 0xFF`, `remainder = 0`, 1-cycle latency.
- Backpressure: hold `out_ready = 0` for 5 cycles in DONE. Required:
  - outputs stay stable and `in_ready` stays 0;
  - `in_valid` with new operands during this window is ignored;
  - after the handshake, `in_ready = 1` on the next cycle.
- Reset mid-CALC: drive `rst_n = 0` at iteration 4. Required:
  - next cycle: state IDLE, `out_valid = 0`, `in_ready = 1`, all outputs 0;
  - a new 0x0064 / 0x0A then yields `quotient = 10`, `remainder = 0`.
